// File: rtl/key_entry_controller.sv
// Debounced hex keypad entry: builds a 4-digit BCD operand, emits operator tokens on a valid/ready port.
// Action lands at the edge taking the DEBOUNCE_CYCLES-th stable sample; tokens hold until out_ready.
// Auto-repeat of digits/backspace is compiled in with `define KEYENTRY_AUTOREPEAT_EN.
module key_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        keypressed,
  input  logic [3:0]  keycode,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_operand,
  output logic [1:0]  out_op,
  output logic [15:0] display_value,
  output logic [2:0]  digit_count,
  output logic        key_strobe,
  output logic        key_dropped
);

  typedef enum logic [1:0] {WAIT_PRESS, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  state_t      state;
  logic [19:0] deb_cnt;
  logic [3:0]  code;

  logic        handshake;
  logic        accept;
  logic        repeat_fire;
  logic        do_act;

  assign handshake = out_valid && out_ready;
  assign accept    = (state == DEB_PRESS) && keypressed && (keycode == code) && (deb_cnt == DEB_LAST);
  assign do_act    = accept || repeat_fire;

  logic [15:0] act_display;
  logic [2:0]  act_count;
  logic        act_strobe;
  logic        act_dropped;
  logic        act_load;
  logic [1:0]  act_op;

  always_comb begin
    act_display = display_value;
    act_count   = digit_count;
    act_strobe  = 1'b1;
    act_dropped = 1'b0;
    act_load    = 1'b0;
    act_op      = 2'd0;
    if (code <= 4'd9) begin
      if (digit_count < 3'd4) begin
        act_display = {display_value[11:0], code};
        act_count   = digit_count + 3'd1;
      end else begin
        act_strobe  = 1'b0;
        act_dropped = 1'b1;
      end
    end else begin
      case (code)
        4'hC: begin
          act_display = 16'h0000;
          act_count   = 3'd0;
        end
        4'hE: begin
          if (digit_count != 3'd0) begin
            act_display = {4'h0, display_value[15:4]};
            act_count   = digit_count - 3'd1;
          end
        end
        default: begin
          case (code)
            4'hA:    act_op = 2'd0;
            4'hB:    act_op = 2'd1;
            4'hD:    act_op = 2'd2;
            default: act_op = 2'd3;
          endcase
          // A token slot freed by this edge's handshake may be refilled at once.
          if (!out_valid || handshake) begin
            act_load    = 1'b1;
            act_display = 16'h0000;
            act_count   = 3'd0;
          end else begin
            act_strobe  = 1'b0;
            act_dropped = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef KEYENTRY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          repeatable;
  logic [RW-1:0] rep_limit;

  assign repeatable  = (code <= 4'd9) || (code == 4'hE);
  assign rep_limit   = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign repeat_fire = (state == HELD) && keypressed && repeatable && (rep_cnt == rep_limit);

  // Counts held edges since the last action; frozen while a release is being debounced.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (accept) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state == HELD && keypressed) begin
      if (repeat_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt   <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= WAIT_PRESS;
      deb_cnt       <= 20'd0;
      code          <= 4'd0;
      out_valid     <= 1'b0;
      out_operand   <= 16'h0000;
      out_op        <= 2'd0;
      display_value <= 16'h0000;
      digit_count   <= 3'd0;
      key_strobe    <= 1'b0;
      key_dropped   <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      key_dropped <= 1'b0;
      if (handshake) out_valid <= 1'b0;
      if (do_act) begin
        display_value <= act_display;
        digit_count   <= act_count;
        key_strobe    <= act_strobe;
        key_dropped   <= act_dropped;
        if (act_load) begin
          out_valid   <= 1'b1;
          out_operand <= display_value;
          out_op      <= act_op;
        end
      end
      case (state)
        WAIT_PRESS: begin
          if (keypressed) begin
            state   <= DEB_PRESS;
            deb_cnt <= 20'd1;
            code    <= keycode;
          end
        end
        DEB_PRESS: begin
          if (!keypressed) begin
            state   <= WAIT_PRESS;
            deb_cnt <= 20'd0;
          end else if (keycode != code) begin
            code    <= keycode;
            deb_cnt <= 20'd1;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            deb_cnt <= 20'd0;
          end else begin
            deb_cnt <= deb_cnt + 20'd1;
          end
        end
        HELD: begin
          if (!keypressed) begin
            state   <= DEB_RELEASE;
            deb_cnt <= 20'd1;
          end
        end
        DEB_RELEASE: begin
          if (keypressed) begin
            state   <= HELD;
            deb_cnt <= 20'd0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= WAIT_PRESS;
            deb_cnt <= 20'd0;
          end else begin
            deb_cnt <= deb_cnt + 20'd1;
          end
        end
        default: state <= WAIT_PRESS;
      endcase
    end
  end

endmodule
